// File: rtl/tx_char_buf.sv
// rtl/tx_char_buf.sv - circular byte buffer that prints its contents to a UART, followed by CR/LF
// Push from the cipher datapath; print_buf drains a snapshot of the current contents.
module tx_char_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_rdy,
  input  logic                     print_buf,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     buf_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    SEND_CR = 2'd2,
    SEND_LF = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   drain_left;
  logic [CW-1:0]   drain_left_nxt;
  logic            pop;
  logic            push;
  logic            drop;
  logic            print_acc;

  assign buf_full = (buf_count == CW'(DEPTH));

  // A pop in the same cycle frees the slot, so a full buffer can still accept the byte.
  assign push = wr_rdy && (!buf_full || pop);
  assign drop = wr_rdy && buf_full && !pop;

  always_comb begin
    state_nxt      = state;
    drain_left_nxt = drain_left;
    tx_valid       = 1'b0;
    tx_data        = 8'h00;
    print_acc      = 1'b0;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        if (print_buf) begin
          print_acc      = 1'b1;
          drain_left_nxt = buf_count;
          state_nxt      = (buf_count != '0) ? DRAIN : SEND_CR;
        end
      end
      DRAIN: begin
        tx_valid = 1'b1;
        tx_data  = mem[head];
        if (tx_ready) begin
          pop            = 1'b1;
          drain_left_nxt = drain_left - CW'(1);
          if (drain_left == CW'(1)) begin
            state_nxt = SEND_CR;
          end
        end
      end
      SEND_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) begin
          state_nxt = SEND_LF;
        end
      end
      SEND_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      buf_count  <= '0;
      drain_left <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_left <= drain_left_nxt;
      buf_count  <= buf_count + CW'(push) - CW'(pop);
      if (pop) begin
        head <= head + AW'(1);
      end
      if (push) begin
        tail <= tail + AW'(1);
      end
      // A drop in the accepting cycle must still be reported, so set wins over clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (print_acc) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= wr_data;
    end
  end

endmodule
